// File: rtl/trig_delay01a.sv
// ---------------------------------------------------------------------------
// trig_delay01a
//
// Programmable delay and one-shot pulse generator. It takes the single-cycle
// rising-edge trigger pulse from the camera-debug trigger edge detector.
// Each accepted trigger produces one output pulse of programmable width. The
// pulse starts a programmable number of cycles after the trigger. A trigger
// that arrives while a sequence is running is rejected and counted as a miss.
//
// Configuration macro:
//   TRIG_DELAY01A_MISS_CNT_EN
//     defined   : miss_count is a saturating count of rejected triggers.
//     undefined : miss_count is tied to 0 and no miss-counter logic is built.
//
// Parameters:
//   DLY_W  width of the delay input and of the delay counter
//   WID_W  width of the width input and of the pulse counter
//   CNT_W  width of trig_count and miss_count
//
// Ports:
//   clk        single clock; all logic is on the rising edge
//   reset      synchronous, active-high reset
//   trigger    one-cycle trigger pulse, synchronous to clk
//   enable     gates acceptance of new triggers only
//   delay      cycles from trigger to pulse start, sampled at accept
//   width      pulse length in cycles, sampled at accept (0 acts as 1)
//   cnt_clr    synchronous clear of both counters
//   pulse_out  generated pulse (registered)
//   busy       high while a sequence is in progress (registered)
//   trig_count number of accepted triggers, wraps
//   miss_count number of rejected triggers, saturates
// ---------------------------------------------------------------------------
module trig_delay01a #(
  parameter int DLY_W = 16,
  parameter int WID_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trigger,
  input  logic             enable,
  input  logic [DLY_W-1:0] delay,
  input  logic [WID_W-1:0] width,
  input  logic             cnt_clr,
  output logic             pulse_out,
  output logic             busy,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);
  localparam logic [WID_W-1:0] WID_ONE = WID_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q,   state_d;
  logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic [WID_W-1:0]   wid_lat_q, wid_lat_d;
  logic [WID_W-1:0]   pls_cnt_q, pls_cnt_d;
  logic               pulse_q,   pulse_d;
  logic               busy_q,    busy_d;
  logic [CNT_W-1:0]   trig_cnt_q, trig_cnt_d;

  logic               accept;
  logic               reject;
  logic [WID_W-1:0]   width_eff;

  // busy_q mirrors "state is not IDLE". Using it for accept/reject keeps
  // these decisions on a single flop output.
  assign accept    = trigger & enable & ~busy_q;
  assign reject    = trigger & enable &  busy_q;

  // A zero width would otherwise never terminate the pulse countdown.
  assign width_eff = (width == '0) ? WID_ONE : width;

  // Next-state logic. The delay and width inputs are only looked at on
  // accept, so mid-sequence changes cannot disturb the running sequence.
  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    wid_lat_d = wid_lat_q;
    pls_cnt_d = pls_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wid_lat_d = width_eff;
          if (delay == '0) begin
            state_d   = ST_PULSE;
            pls_cnt_d = width_eff;
          end else begin
            state_d   = ST_DELAY;
            dly_cnt_d = delay;
          end
        end
      end

      ST_DELAY: begin
        // Delay counter holds the remaining DELAY cycles, including this one.
        if (dly_cnt_q == DLY_ONE) begin
          state_d   = ST_PULSE;
          pls_cnt_d = wid_lat_q;
        end else begin
          dly_cnt_d = dly_cnt_q - DLY_ONE;
        end
      end

      ST_PULSE: begin
        if (pls_cnt_q == WID_ONE) begin
          state_d = ST_IDLE;
        end else begin
          pls_cnt_d = pls_cnt_q - WID_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so pulse_out
  // and busy come straight off flops and cannot glitch.
  always_comb begin
    pulse_d = (state_d == ST_PULSE);
    busy_d  = (state_d != ST_IDLE);
  end

  // Accepted-trigger counter. A clear wins over a simultaneous increment.
  always_comb begin
    trig_cnt_d = trig_cnt_q;
    if (cnt_clr) begin
      trig_cnt_d = '0;
    end else if (accept) begin
      trig_cnt_d = trig_cnt_q + CNT_ONE;
    end
  end

  // Sequencer and accepted-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dly_cnt_q  <= '0;
      wid_lat_q  <= '0;
      pls_cnt_q  <= '0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      trig_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      wid_lat_q  <= wid_lat_d;
      pls_cnt_q  <= pls_cnt_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      trig_cnt_q <= trig_cnt_d;
    end
  end

`ifdef TRIG_DELAY01A_MISS_CNT_EN
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Rejected-trigger counter. It saturates at all-ones so that a stuck
  // trigger line reads as "many" rather than wrapping back to a small value.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (cnt_clr) begin
      miss_cnt_d = '0;
    end else if (reject && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_count = miss_cnt_q;
`else
  // Rejected triggers are still ignored by the sequencer. They are just
  // not counted in this build.
  logic unused_reject;
  assign unused_reject = reject;
  assign miss_count    = '0;
`endif

  assign pulse_out  = pulse_q;
  assign busy       = busy_q;
  assign trig_count = trig_cnt_q;

endmodule

// File: tb/tb_trig_delay01a.sv
// ---------------------------------------------------------------------------
// tb_trig_delay01a
//
// Self-checking bench for trig_delay01a, built with CNT_W = 4 so that
// counter wrap and saturation are reachable in a few cycles. A cycle table
// holds the inputs for each cycle and the outputs expected in that cycle.
// Hand-written sequences follow for counter wrap, saturation and clear.
// The expected miss_count follows TRIG_DELAY01A_MISS_CNT_EN.
// ---------------------------------------------------------------------------
module tb_trig_delay01a;

  logic        clk;
  logic        reset;
  logic        trigger;
  logic        enable;
  logic [15:0] delay;
  logic [15:0] width;
  logic        cnt_clr;
  logic        pulse_out;
  logic        busy;
  logic [3:0]  trig_count;
  logic [3:0]  miss_count;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic        trig;
    logic        en;
    logic [15:0] dly;
    logic [15:0] wid;
    logic        clr;
    logic        rst;
    logic        expPulse;
    logic        expBusy;
    logic [3:0]  expTc;
    logic [3:0]  expMc;
  } vec_t;

  vec_t vecs[$];

  trig_delay01a #(
    .DLY_W(16),
    .WID_W(16),
    .CNT_W(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .enable     (enable),
    .delay      (delay),
    .width      (width),
    .cnt_clr    (cnt_clr),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .trig_count (trig_count),
    .miss_count (miss_count)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // In a build without the miss counter, miss_count always reads 0.
  function automatic logic [3:0] expMiss(input logic [3:0] v);
`ifdef TRIG_DELAY01A_MISS_CNT_EN
    return v;
`else
    return 4'd0;
`endif
  endfunction

  function automatic vec_t mk(input logic t, input logic e, input logic [15:0] d,
                              input logic [15:0] w, input logic c, input logic r,
                              input logic p, input logic b, input logic [3:0] tc,
                              input logic [3:0] mc);
    vec_t v;
    v.trig = t; v.en = e; v.dly = d; v.wid = w; v.clr = c; v.rst = r;
    v.expPulse = p; v.expBusy = b; v.expTc = tc; v.expMc = mc;
    return v;
  endfunction

  // Drive the inputs for one cycle. Return at the next falling edge, where
  // the outputs of the following cycle are stable.
  task automatic applyStimulus(input logic t, input logic e, input logic [15:0] d,
                               input logic [15:0] w, input logic c, input logic r);
    trigger = t;
    enable  = e;
    delay   = d;
    width   = w;
    cnt_clr = c;
    reset   = r;
    @(negedge clk);
  endtask

  // Compare the four outputs of the current cycle against expectations.
  task automatic checkOutput(input string name, input logic p, input logic b,
                             input logic [3:0] tc, input logic [3:0] mc);
    logic [3:0] mcExp;
    mcExp = expMiss(mc);
    testsRun++;
    if (pulse_out !== p) begin
      testsFailed++;
      $display("[TB] FAIL %s pulse_out: got %0b, expected %0b", name, pulse_out, p);
    end
    testsRun++;
    if (busy !== b) begin
      testsFailed++;
      $display("[TB] FAIL %s busy: got %0b, expected %0b", name, busy, b);
    end
    testsRun++;
    if (trig_count !== tc) begin
      testsFailed++;
      $display("[TB] FAIL %s trig_count: got %0d, expected %0d", name, trig_count, tc);
    end
    testsRun++;
    if (miss_count !== mcExp) begin
      testsFailed++;
      $display("[TB] FAIL %s miss_count: got %0d, expected %0d", name, miss_count, mcExp);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    trigger = 1'b0; enable = 1'b0; delay = '0; width = '0;
    cnt_clr = 1'b0; reset = 1'b1;

    // Delay 3, width 2: pulse in cycles 4-5, busy 1-5. Delay/width are
    // changed mid-sequence and must have no effect.
    vecs.push_back(mk(1,1,3,2,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,0,7,0,0, 0,1,1,0));
    vecs.push_back(mk(0,1,0,7,0,0, 0,1,1,0));
    vecs.push_back(mk(0,1,3,2,0,0, 0,1,1,0));
    vecs.push_back(mk(0,1,3,2,0,0, 1,1,1,0));
    vecs.push_back(mk(0,1,3,2,0,0, 1,1,1,0));
    vecs.push_back(mk(0,1,3,2,0,0, 0,0,1,0));
    // Delay 0, width 0: a single pulse in cycle 1.
    vecs.push_back(mk(1,1,0,0,0,0, 0,0,1,0));
    vecs.push_back(mk(0,1,0,0,0,0, 1,1,2,0));
    vecs.push_back(mk(0,1,0,0,0,0, 0,0,2,0));
    // Delay 2, width 2: triggers in cycles 0,3,4 (two misses), 5 accepted.
    vecs.push_back(mk(1,1,2,2,0,0, 0,0,2,0));
    vecs.push_back(mk(0,1,2,2,0,0, 0,1,3,0));
    vecs.push_back(mk(0,1,2,2,0,0, 0,1,3,0));
    vecs.push_back(mk(1,1,2,2,0,0, 1,1,3,0));
    vecs.push_back(mk(1,1,2,2,0,0, 1,1,3,1));
    vecs.push_back(mk(1,1,2,2,0,0, 0,0,3,2));
    vecs.push_back(mk(0,1,2,2,0,0, 0,1,4,2));
    vecs.push_back(mk(0,1,2,2,0,0, 0,1,4,2));
    vecs.push_back(mk(0,1,2,2,0,0, 1,1,4,2));
    vecs.push_back(mk(0,1,2,2,0,0, 1,1,4,2));
    vecs.push_back(mk(0,1,2,2,0,0, 0,0,4,2));
    // Trigger with enable low is ignored.
    vecs.push_back(mk(1,0,2,2,0,0, 0,0,4,2));
    vecs.push_back(mk(0,1,2,2,0,0, 0,0,4,2));
    // Delay 5, width 1, enable dropped in cycle 2: pulse still in cycle 6.
    vecs.push_back(mk(1,1,5,1,0,0, 0,0,4,2));
    vecs.push_back(mk(0,1,5,1,0,0, 0,1,5,2));
    vecs.push_back(mk(0,0,5,1,0,0, 0,1,5,2));
    vecs.push_back(mk(1,0,5,1,0,0, 0,1,5,2));
    vecs.push_back(mk(0,0,5,1,0,0, 0,1,5,2));
    vecs.push_back(mk(0,0,5,1,0,0, 0,1,5,2));
    vecs.push_back(mk(0,0,5,1,0,0, 1,1,5,2));
    vecs.push_back(mk(0,0,5,1,0,0, 0,0,5,2));
    // Delay 10, reset (with a trigger) in cycle 4. A new trigger in cycle 6
    // uses delay 1 and width 1, so the pulse is in cycle 8 and cycle 11 is quiet.
    vecs.push_back(mk(1,1,10,1,0,0, 0,0,5,2));
    vecs.push_back(mk(0,1,10,1,0,0, 0,1,6,2));
    vecs.push_back(mk(0,1,10,1,0,0, 0,1,6,2));
    vecs.push_back(mk(0,1,10,1,0,0, 0,1,6,2));
    vecs.push_back(mk(1,1,10,1,0,1, 0,1,6,2));
    vecs.push_back(mk(0,1,1,1,0,0,  0,0,0,0));
    vecs.push_back(mk(1,1,1,1,0,0,  0,0,0,0));
    vecs.push_back(mk(0,1,1,1,0,0,  0,1,1,0));
    vecs.push_back(mk(0,1,1,1,0,0,  1,1,1,0));
    vecs.push_back(mk(0,1,1,1,0,0,  0,0,1,0));
    vecs.push_back(mk(0,1,1,1,0,0,  0,0,1,0));
    vecs.push_back(mk(0,1,1,1,0,0,  0,0,1,0));

    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      checkOutput($sformatf("row%0d", k), vecs[k].expPulse, vecs[k].expBusy,
                  vecs[k].expTc, vecs[k].expMc);
      applyStimulus(vecs[k].trig, vecs[k].en, vecs[k].dly, vecs[k].wid,
                    vecs[k].clr, vecs[k].rst);
    end

    // Clear, then 16 spaced accepts (delay 0, width 1) wrap trig_count to 0.
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("clear", 0, 0, 4'd0, 4'd0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1, 1, 0, 1, 0, 0);
      applyStimulus(0, 1, 0, 1, 0, 0);
      checkOutput($sformatf("wrap%0d", i), 0, 0, 4'(i), 4'd0);
    end

    // Delay 30: one accept followed by 20 back-to-back rejected triggers.
    applyStimulus(1, 1, 30, 1, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1, 1, 30, 1, 0, 0);
      if (i == 10) checkOutput("miss10", 0, 1, 4'd1, 4'd10);
    end
    checkOutput("missSat", 0, 1, 4'd1, 4'd15);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("satPulse", 1, 1, 4'd1, 4'd15);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("satDone", 0, 0, 4'd1, 4'd15);

    // A clear together with an accept leaves both counters at 0.
    applyStimulus(1, 1, 0, 1, 1, 0);
    checkOutput("clrAccept", 1, 1, 4'd0, 4'd0);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("clrAcceptIdle", 0, 0, 4'd0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
